// File: rtl/segre_mem_arbiter.sv
// Request/grant arbiter sharing the single external memory port between NUM_PORTS
// requesters, with round-robin or fixed-priority selection and in-order read-response routing.

package segre_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;
endpackage

module segre_mem_arbiter
  import segre_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned PRIO_MODE   = 0
) (
  input  logic                          clk_i,
  input  logic                          rsn_i,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS-1:0]          we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
  input  memop_data_type_e [NUM_PORTS-1:0] dtype_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic [NUM_PORTS-1:0]          rvalid_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_rd_o,
  output logic                          mem_wr_o,
  output logic [DATA_W-1:0]             mem_wr_data_o,
  output memop_data_type_e              mem_data_type_o,
  input  logic [DATA_W-1:0]             mem_rd_data_i
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IDX_W-1:0]                   r_ptr;
  logic [MEM_LATENCY-1:0]             r_trk_vld;
  logic [MEM_LATENCY-1:0][IDX_W-1:0]  r_trk_idx;

  logic                               w_sel_vld;
  logic [IDX_W-1:0]                   w_sel_idx;
  logic [IDX_W-1:0]                   w_cand;

  // Scan from ptr (round-robin) or from port 0 (fixed priority); first requester wins
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_cand    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_cand = IDX_W'((PRIO_MODE != 0) ? i : ((32'(r_ptr) + i) % NUM_PORTS));
      if (!w_sel_vld && req_i[w_cand]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = w_cand;
      end
    end
  end

  // Memory port mux; idle cycles drive a clean all-zero access of WORD size
  always_comb begin
    gnt_o           = '0;
    mem_addr_o      = '0;
    mem_rd_o        = 1'b0;
    mem_wr_o        = 1'b0;
    mem_wr_data_o   = '0;
    mem_data_type_o = WORD;
    if (w_sel_vld) begin
      gnt_o[w_sel_idx] = 1'b1;
      mem_addr_o       = addr_i[w_sel_idx*ADDR_W +: ADDR_W];
      mem_wr_data_o    = wdata_i[w_sel_idx*DATA_W +: DATA_W];
      mem_data_type_o  = dtype_i[w_sel_idx];
      mem_rd_o         = !we_i[w_sel_idx];
      mem_wr_o         = we_i[w_sel_idx];
    end
  end

  // Last tracking stage lines up with the memory's read data
  always_comb begin
    rvalid_o = '0;
    if (r_trk_vld[MEM_LATENCY-1]) begin
      rvalid_o[r_trk_idx[MEM_LATENCY-1]] = 1'b1;
    end
  end

  assign rdata_o = mem_rd_data_i;

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      r_ptr     <= '0;
      r_trk_vld <= '0;
      r_trk_idx <= '0;
    end else begin
      if (PRIO_MODE == 0 && w_sel_vld) begin
        r_ptr <= (w_sel_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_sel_idx + 1'b1;
      end
      r_trk_vld[0] <= w_sel_vld && !we_i[w_sel_idx];
      r_trk_idx[0] <= w_sel_idx;
      for (int unsigned s = 1; s < MEM_LATENCY; s++) begin
        r_trk_vld[s] <= r_trk_vld[s-1];
        r_trk_idx[s] <= r_trk_idx[s-1];
      end
    end
  end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Scoreboard bench: a round-robin instance (latency 3) and a fixed-priority instance
// (latency 1) driven by random requesters and checked against a behavioural model.
module tb_segre_mem_arbiter;
  import segre_mem_arbiter_pkg::*;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          d;
    int          due;
    int          port;
    logic [31:0] data;
  } exp_t;

  logic clk_i = 1'b0;
  logic rsn   = 1'b1;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  logic [NP-1:0]       req      [2];
  logic [NP-1:0]       we       [2];
  logic [NP*AW-1:0]    addr     [2];
  logic [NP*DW-1:0]    wdata    [2];
  memop_data_type_e [NP-1:0] dtype [2];
  logic [NP-1:0]       gnt      [2];
  logic [NP-1:0]       rvalid   [2];
  logic [DW-1:0]       rdata    [2];
  logic [AW-1:0]       mem_addr [2];
  logic                mem_rd   [2];
  logic                mem_wr   [2];
  logic [DW-1:0]       mem_wdata[2];
  memop_data_type_e    mem_dt   [2];
  logic [DW-1:0]       mem_rdata[2];

  logic [NP-1:0]       pend     [2];
  int                  ref_ptr  [2];
  logic [31:0]         ref_mem  [int];
  logic [31:0]         env_mem  [int];
  logic [31:0]         pend_rd  [int];
  exp_t                exp_q    [$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  segre_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .PRIO_MODE(0)) u_rr (
    .clk_i(clk_i), .rsn_i(rsn), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .dtype_i(dtype[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .mem_addr_o(mem_addr[0]), .mem_rd_o(mem_rd[0]), .mem_wr_o(mem_wr[0]),
    .mem_wr_data_o(mem_wdata[0]), .mem_data_type_o(mem_dt[0]), .mem_rd_data_i(mem_rdata[0]));

  segre_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .PRIO_MODE(1)) u_fp (
    .clk_i(clk_i), .rsn_i(rsn), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .dtype_i(dtype[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .mem_addr_o(mem_addr[1]), .mem_rd_o(mem_rd[1]), .mem_wr_o(mem_wr[1]),
    .mem_wr_data_o(mem_wdata[1]), .mem_data_type_o(mem_dt[1]), .mem_rd_data_i(mem_rdata[1]));

  function automatic int lat(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic int key(input int d, input logic [31:0] a);
    return d * 65536 + int'(a[15:0]);
  endfunction

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_rd(input int d, input logic [31:0] a);
    return ref_mem.exists(key(d, a)) ? ref_mem[key(d, a)] : mem_init(a);
  endfunction

  // Winner: lowest requesting index (fixed) or first requester at/after ptr with wrap (round-robin)
  function automatic int pick(input int d, input logic [NP-1:0] r, input int ptr);
    if (d == 1) begin
      for (int c = 0; c < NP; c++) if (r[c]) return c;
      return -1;
    end
    for (int c = ptr; c < NP; c++) if (r[c]) return c;
    for (int c = 0; c < ptr; c++) if (r[c]) return c;
    return -1;
  endfunction

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  // External memory: captures reads at grant and presents the data MEM_LATENCY cycles later
  always @(negedge clk_i) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_rd[d]) begin
        pend_rd[d * 1000000 + cyc + lat(d)] =
          env_mem.exists(key(d, mem_addr[d])) ? env_mem[key(d, mem_addr[d])] : mem_init(mem_addr[d]);
      end
      if (mem_wr[d]) env_mem[key(d, mem_addr[d])] = mem_wdata[d];
    end
  end

  always @(posedge clk_i) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      int kk;
      kk = d * 1000000 + cyc;
      mem_rdata[d] = pend_rd.exists(kk) ? pend_rd[kk] : $urandom();
    end
  end

  // Monitor: every returning read must match the oldest outstanding read of that instance
  always @(negedge clk_i) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        int   qi;
        exp_t e;
        qi = -1;
        for (int i = 0; i < exp_q.size(); i++) if (qi < 0 && exp_q[i].d == d) qi = i;
        if (rvalid[d] != '0) begin
          if (qi < 0) begin
            chk("rvalid_unexpected", d, 128'(rvalid[d]), 128'(0));
          end else begin
            e = exp_q[qi];
            exp_q.delete(qi);
            chk("rvalid_cycle", d, 128'(cyc), 128'(e.due));
            chk("rvalid_port", d, 128'(rvalid[d]), 128'(NP'(1) << e.port));
            chk("rdata", d, 128'(rdata[d]), 128'(e.data));
          end
        end else if (qi >= 0 && exp_q[qi].due <= cyc) begin
          chk("rvalid_missing", d, 128'(rvalid[d]), 128'(NP'(1) << exp_q[qi].port));
          exp_q.delete(qi);
        end
      end
    end
  end

  task automatic issue(input int d, input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input memop_data_type_e dt);
    pend[d][p]              = 1'b1;
    we[d][p]                = w;
    addr[d][p*AW +: AW]     = a;
    wdata[d][p*DW +: DW]    = wd;
    dtype[d][p]             = dt;
  endtask

  task automatic gen_reqs(input int load);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[d][p] && int'($urandom_range(0, 99)) < load) begin
          issue(d, p, ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 31)) << 2, $urandom(),
                memop_data_type_e'(2'($urandom_range(0, 2))));
        end
      end
    end
  endtask

  // Model of one cycle: expected grant and memory bus, then pointer/response bookkeeping
  task automatic eval_cycle();
    for (int d = 0; d < 2; d++) begin
      int            k;
      logic [NP-1:0] eg;
      logic [67:0]   eb;
      logic [67:0]   ab;
      logic [31:0]   a;
      logic [31:0]   w;
      exp_t          e;
      k  = pick(d, req[d], ref_ptr[d]);
      eg = '0;
      a  = '0;
      w  = '0;
      eb = {32'h0, 1'b0, 1'b0, 32'h0, WORD};
      if (k >= 0) begin
        eg[k] = 1'b1;
        a  = addr[d][k*AW +: AW];
        w  = wdata[d][k*DW +: DW];
        eb = {a, ~we[d][k], we[d][k], w, dtype[d][k]};
      end
      ab = {mem_addr[d], mem_rd[d], mem_wr[d], mem_wdata[d], mem_dt[d]};
      chk("grant", d, 128'(gnt[d]), 128'(eg));
      chk("mem_bus", d, 128'(ab), 128'(eb));
      if (k >= 0) begin
        pend[d][k] = 1'b0;
        if (we[d][k]) begin
          ref_mem[key(d, a)] = w;
        end else if (!rsn) begin
          e.d = d; e.due = cyc + lat(d); e.port = k; e.data = ref_rd(d, a);
          exp_q.push_back(e);
        end
        if (!rsn) ref_ptr[d] = (k + 1) % NP;
      end
      if (rsn) begin
        ref_ptr[d] = 0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (exp_q[i].d == d && exp_q[i].due > cyc) exp_q.delete(i);
        end
      end
    end
  endtask

  task automatic step(input bit quiet);
    for (int d = 0; d < 2; d++) req[d] = pend[d];
    @(negedge clk_i);
    eval_cycle();
    if (quiet) for (int d = 0; d < 2; d++) chk("rvalid_quiet", d, 128'(rvalid[d]), 128'(0));
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend[0] != '0 || pend[1] != '0 || exp_q.size() != 0) && n < 60) begin
      step(1'b0);
      n++;
    end
    chk("drain", 0, 128'({pend[0], pend[1], 32'(exp_q.size())}), 128'(0));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0; pend[d] = '0; ref_ptr[d] = 0;
      for (int p = 0; p < NP; p++) dtype[d][p] = WORD;
    end
    rsn = 1'b1;
    step(1'b1);
    step(1'b1);
    rsn    = 1'b0;
    mon_en = 1'b1;

    // Full contention straight out of reset
    for (int i = 0; i < 6; i++) begin
      gen_reqs(100);
      step(1'b0);
    end

    // Random traffic with varying load
    for (int i = 0; i < 400; i++) begin
      gen_reqs(int'($urandom_range(20, 100)));
      step(1'b0);
    end
    drain();

    // Back-to-back read / HALF write / read on the latency-1 instance
    issue(1, 0, 1'b0, 32'h10, 32'h0, WORD);
    step(1'b0);
    issue(1, 1, 1'b1, 32'h20, 32'h0000_CAFE, HALF);
    step(1'b0);
    issue(1, 0, 1'b0, 32'h14, 32'h0, WORD);
    step(1'b0);
    issue(1, 2, 1'b0, 32'h20, 32'h0, BYTE);
    step(1'b0);
    drain();

    // Reset while reads are in flight: responses dropped, pointer back to 0
    issue(0, 1, 1'b0, 32'h100, 32'h0, WORD);
    issue(1, 1, 1'b0, 32'h104, 32'h0, WORD);
    step(1'b0);
    rsn = 1'b1;
    step(1'b0);
    rsn = 1'b0;
    repeat (4) step(1'b1);
    gen_reqs(100);
    step(1'b0);
    drain();

    for (int i = 0; i < 200; i++) begin
      gen_reqs(int'($urandom_range(10, 100)));
      step(1'b0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

Parametrised arbiter that shares the single external memory port between `NUM_PORTS` requesters: instruction fetch, load/store unit, and future requesters such as a debug or DMA port. It replaces the fixed IF/MEM multiplexing, which was selected by the controller FSM state, with a request/grant handshake. Arbitration is round-robin or fixed-priority, and read data is routed back to the issuing port after a fixed memory latency. It sits between the core stages and the memory interface.

## Interface
- `NUM_PORTS`, 2: number of requesters; 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_LATENCY`, 1: cycles from memory read issue to valid `mem_rd_data_i`; 1..4.
- `PRIO_MODE`, 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `rsn_i`, in, 1: reset. Synchronous, active-high.
- `req_i`, in, `NUM_PORTS`: per-port request.
- `we_i`, in, `NUM_PORTS`: per-port write enable. 1 = store, 0 = load.
- `addr_i`, in, `NUM_PORTS*ADDR_W`: per-port address. Port k occupies bits `[k*ADDR_W +: ADDR_W]`.
- `wdata_i`, in, `NUM_PORTS*DATA_W`: per-port store data, packed the same way.
- `dtype_i`, in, `NUM_PORTS` × `memop_data_type_e`: per-port access size (BYTE/HALF/WORD).
- `gnt_o`, out, `NUM_PORTS`: one-hot grant, same cycle as the accepted request.
- `rvalid_o`, out, `NUM_PORTS`: one-hot read-data-valid for the port owning the returning load.
- `rdata_o`, out, `DATA_W`: read data, shared by all ports; qualified by `rvalid_o`.
- `mem_addr_o`, out, `ADDR_W`: memory address.
- `mem_rd_o`, out, 1: memory read strobe.
- `mem_wr_o`, out, 1: memory write strobe.
- `mem_wr_data_o`, out, `DATA_W`: memory store data.
- `mem_data_type_o`, out, `memop_data_type_e`: memory access size.
- `mem_rd_data_i`, in, `DATA_W`: memory read data.

## Operation
- The memory accepts one access per cycle, unconditionally. At most one port is granted per cycle.
- **Selection**
  - Combinational from `req_i` and the priority pointer `ptr`.
  - Round-robin: the first requesting port found scanning `ptr`, `ptr+1`, … modulo `NUM_PORTS`.
  - Fixed priority: the lowest-index requesting port. `ptr` is ignored.
- **Granted port k**
  - `gnt_o[k]`=1.
  - `mem_addr_o`, `mem_wr_data_o` and `mem_data_type_o` come from port k.
  - `mem_rd_o` = `!we_i[k]`.
  - `mem_wr_o` = `we_i[k]`.
- **No request**
  - `gnt_o`=0, `mem_rd_o`=0, `mem_wr_o`=0.
  - `mem_addr_o`=0, `mem_wr_data_o`=0, `mem_data_type_o`=WORD.
- **Pointer update**
  - Round-robin: on each grant, `ptr` <= (k+1) mod `NUM_PORTS`. `ptr` is unchanged in idle cycles.
- **Requester rule**
  - A port holds `req_i`, `we_i`, `addr_i`, `wdata_i` and `dtype_i` stable until it sees `gnt_o`.
  - A port may deassert `req_i` only in the cycle after its grant, or re-request immediately for back-to-back accesses.
- **Response tracking**
  - A `MEM_LATENCY`-deep shift register of {valid, port index}.
  - On a granted read, stage 0 loads {1, k}. Writes and idle cycles load {0, x}.
  - Each stage advances every cycle.
  - When the last stage is valid, `rvalid_o[idx]`=1.
- **Read data**
  - `rdata_o` = `mem_rd_data_i`, combinational passthrough, with no sign/zero extension. Extension is done by the requester.
- Writes never produce `rvalid_o`.
- Reads issued on consecutive cycles return on consecutive cycles, in issue order.

## Timing
- Reset (`rsn_i`=1 at a clock edge):
  - `ptr`=0 and all tracking stages are cleared.
  - In the cycle after the reset edge: `rvalid_o`=0.
  - `gnt_o` and the memory outputs stay combinational and follow `req_i` even during reset.
- Reset while reads are in flight: their `rvalid_o` pulses are dropped and never appear.
- Grant latency: 0 cycles when the port wins arbitration.
- Worst-case wait in round-robin: `NUM_PORTS`-1 cycles under full contention.
- Read grant in cycle t: `rvalid_o[k]`=1 for exactly one cycle, at t+`MEM_LATENCY`.
- Full throughput: one access per cycle with no bubbles, including a read followed by a write.
- Response for a read and a new grant in the same cycle are independent.
- Pointer wrap: after a grant to port `NUM_PORTS`-1, `ptr`=0.
- `NUM_PORTS`=2, `PRIO_MODE`=0, both ports requesting continuously: grants alternate 0,1,0,1 from reset.

## Test plan
- **Reset defaults**: `NUM_PORTS`=2, `rsn_i`=1 for 2 cycles, `req_i`=0 → `gnt_o`=0, `rvalid_o`=0, `mem_rd_o`=0, `mem_wr_o`=0, `mem_data_type_o`=WORD.
- **Single read**: `MEM_LATENCY`=2; port 1 reads `addr`=0x100 at cycle t; memory returns 0xDEADBEEF → `gnt_o`=2'b10 at t, `mem_addr_o`=0x100, `mem_rd_o`=1; `rvalid_o`=2'b10 and `rdata_o`=0xDEADBEEF at t+2 only.
- **Round-robin contention**: `NUM_PORTS`=3, all ports requesting for 6 cycles → grant sequence 0,1,2,0,1,2; no port gets two consecutive grants.
- **Fixed priority**: `PRIO_MODE`=1, ports 0 and 2 requesting for 3 cycles → `gnt_o`=3'b001 in all 3 cycles; port 2 is granted in the first cycle after port 0 drops.
- **Back-to-back mixed ops**: `MEM_LATENCY`=1; port 0 reads 0x10 at t, port 1 writes 0xCAFE to 0x20 with HALF at t+1, port 0 reads 0x14 at t+2:
  - At t+1: `mem_wr_o`=1, `mem_wr_data_o`=0xCAFE, `mem_data_type_o`=HALF.
  - `rvalid_o[0]` at t+1 and t+3; `rvalid_o` is 0 at t+2.
- **Reset mid-flight**: `MEM_LATENCY`=3; read granted at t; `rsn_i`=1 at t+1 → `rvalid_o` stays 0 through t+5; `ptr`=0 afterwards.
